// File: rtl/scs_pkg.sv
// Shared types and helpers for the SCS-32 crosstalk-avoidance link.
// Coded flit layout: [31] inv flag, [30:0] payload (inverted when the flag is set).
package scs_pkg;

    localparam int FLIT_W    = 32;
    localparam int FLAG_BIT  = 31;
    localparam int PAYLOAD_W = 31;

    typedef logic [FLIT_W-1:0] coded_flit_t;

    typedef struct packed {
        logic                 inv;
        logic [PAYLOAD_W-1:0] payload;
    } rx_entry_t;

    function automatic rx_entry_t scs_decode(input coded_flit_t f);
        rx_entry_t e;
        e.inv     = f[FLAG_BIT];
        e.payload = f[PAYLOAD_W-1:0] ^ {PAYLOAD_W{f[FLAG_BIT]}};
        return e;
    endfunction

endpackage

// File: rtl/scs_t2_pair_count.sv
// Counts opposing adjacent-bit transitions (10->01 or 01->10) between two flits.
// Ports: prev, cur (32b coded flits); count (0..31 opposing pairs).
module scs_t2_pair_count
    import scs_pkg::*;
(
    input  logic [FLIT_W-1:0] prev,
    input  logic [FLIT_W-1:0] cur,
    output logic [4:0]        count
);

    logic [1:0] p;
    logic [1:0] c;

    always_comb begin
        count = '0;
        p     = '0;
        c     = '0;
        for (int i = 0; i < FLIT_W - 1; i++) begin
            p = {prev[i+1], prev[i]};
            c = {cur[i+1], cur[i]};
            if ((p == 2'b10 && c == 2'b01) || (p == 2'b01 && c == 2'b10))
                count = count + 5'd1;
        end
    end

endmodule

// File: rtl/scs_flit_rx.sv
// SCS-32 receive end: decodes coded flits, buffers them in a FIFO and keeps link stats.
// Ports: clk, rst_n; in_valid/in_ready/in_data (coded); out_valid/out_ready/out_data/out_inv
// (decoded); stat_clr; flit_cnt, inv_cnt, t2_cnt (saturating statistics).
module scs_flit_rx
    import scs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLIT_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_inv,
    input  logic                 stat_clr,
    output logic [CNT_W-1:0]     flit_cnt,
    output logic [CNT_W-1:0]     inv_cnt,
    output logic [CNT_W-1:0]     t2_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam int SW = CNT_W + 6;

    rx_entry_t   mem [DEPTH];
    rx_entry_t   head;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    coded_flit_t   prev_flit;
    logic [4:0]    pair_cnt;
    logic [SW-1:0] t2_sum;
    logic          accept;
    logic          pop;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head is masked while empty so stale contents never leak after reset.
    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head.payload : '0;
    assign out_inv  = out_valid ? head.inv : 1'b0;

    scs_t2_pair_count u_t2 (
        .prev  (prev_flit),
        .cur   (in_data),
        .count (pair_cnt)
    );

    assign t2_sum = SW'(t2_cnt) + SW'(pair_cnt);

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= scs_decode(in_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_flit <= '0;
        end else if (accept) begin
            prev_flit <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt <= '0;
            inv_cnt  <= '0;
            t2_cnt   <= '0;
        end else if (stat_clr) begin
            flit_cnt <= '0;
            inv_cnt  <= '0;
            t2_cnt   <= '0;
        end else if (accept) begin
            if (flit_cnt != CNT_MAX)
                flit_cnt <= flit_cnt + 1'b1;
            if (in_data[FLAG_BIT] && inv_cnt != CNT_MAX)
                inv_cnt <= inv_cnt + 1'b1;
            if (t2_sum > SW'(CNT_MAX))
                t2_cnt <= CNT_MAX;
            else
                t2_cnt <= t2_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_scs_flit_rx.sv
// Directed self-checking bench for scs_flit_rx.
// A CNT_W=4 copy shares the stimulus to exercise counter saturation.
module tb_scs_flit_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        stat_clr = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [30:0] out_data;
    logic        out_inv;
    logic [15:0] flit_cnt;
    logic [15:0] inv_cnt;
    logic [15:0] t2_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [30:0] s_out_data;
    logic        s_out_inv;
    logic [3:0]  s_flit_cnt;
    logic [3:0]  s_inv_cnt;
    logic [3:0]  s_t2_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    scs_flit_rx #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_inv   (out_inv),
        .stat_clr  (stat_clr),
        .flit_cnt  (flit_cnt),
        .inv_cnt   (inv_cnt),
        .t2_cnt    (t2_cnt)
    );

    scs_flit_rx #(.DEPTH(4), .CNT_W(4)) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data),
        .out_inv   (s_out_inv),
        .stat_clr  (stat_clr),
        .flit_cnt  (s_flit_cnt),
        .inv_cnt   (s_inv_cnt),
        .t2_cnt    (s_t2_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stat_clr  = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic put(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_flit_cnt", 32'(flit_cnt), 32'd0);

        // 1: flag-only flit decodes to all-ones payload
        out_ready = 1'b1;
        put(32'h8000_0000);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h7FFF_FFFF);
        chk("t1_inv", 32'(out_inv), 32'd1);
        chk("t1_flit", 32'(flit_cnt), 32'd1);
        chk("t1_inv_cnt", 32'(inv_cnt), 32'd1);
        step();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // 2: fill to full, then drain in order
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k);
            chk($sformatf("t2_in_ready_%0d", k), 32'(in_ready),
                (k <= 4) ? 32'd1 : 32'd0);
            step();
        end
        in_valid = 1'b0;
        chk("t2_flit", 32'(flit_cnt), 32'd4);
        chk("t2_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t2_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("t2_data_%0d", k), 32'(out_data), 32'(k));
            step();
        end
        chk("t2_empty", 32'(out_valid), 32'd0);
        chk("t2_ready", 32'(in_ready), 32'd1);

        // 3: opposing-transition counting
        do_reset();
        put(32'h0000_0002);
        put(32'h0000_0001);
        chk("t3_t2_one", 32'(t2_cnt), 32'd1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("t3_clr", 32'(t2_cnt), 32'd0);
        // 0x1 -> 0x2AAAAAAA opposes at i=0 only; then 30 pairs
        put(32'h2AAA_AAAA);
        chk("t3_t2_a", 32'(t2_cnt), 32'd1);
        put(32'h5555_5555);
        chk("t3_t2_31", 32'(t2_cnt), 32'd31);

        // 4: full FIFO with both handshakes asserted
        do_reset();
        for (int k = 1; k <= 4; k++) put(32'(k));
        in_valid  = 1'b1;
        in_data   = 32'h0000_0077;
        out_ready = 1'b1;
        chk("t4_full", 32'(in_ready), 32'd0);
        step();
        chk("t4_pop_ready", 32'(in_ready), 32'd1);
        chk("t4_pop_data", 32'(out_data), 32'd2);
        chk("t4_no_accept", 32'(flit_cnt), 32'd4);
        in_data = 32'h0000_0009;
        step();
        chk("t4_both_flit", 32'(flit_cnt), 32'd5);
        chk("t4_both_data", 32'(out_data), 32'd3);
        chk("t4_both_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        in_data   = 32'h0000_000A;
        step();
        in_valid = 1'b0;
        chk("t4_refull", 32'(in_ready), 32'd0);

        // 5: saturation on the narrow copy, clear beats increment
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) put(32'h8000_0000);
        chk("t5_s_flit", 32'(s_flit_cnt), 32'd15);
        chk("t5_s_inv", 32'(s_inv_cnt), 32'd15);
        chk("t5_flit", 32'(flit_cnt), 32'd20);
        chk("t5_inv", 32'(inv_cnt), 32'd20);
        stat_clr = 1'b1;
        put(32'hFFFF_FFFF);
        stat_clr = 1'b0;
        chk("t5_clr_s_flit", 32'(s_flit_cnt), 32'd0);
        chk("t5_clr_s_inv", 32'(s_inv_cnt), 32'd0);
        chk("t5_clr_s_t2", 32'(s_t2_cnt), 32'd0);
        chk("t5_clr_flit", 32'(flit_cnt), 32'd0);
        chk("t5_clr_t2", 32'(t2_cnt), 32'd0);

        // 6: asynchronous reset with flits buffered
        do_reset();
        put(32'h8000_0011);
        put(32'h8000_0022);
        put(32'h8000_0033);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd1);
        chk("t6_flit", 32'(flit_cnt), 32'd0);
        chk("t6_inv", 32'(inv_cnt), 32'd0);
        chk("t6_data", 32'(out_data), 32'd0);
        chk("t6_inv_out", 32'(out_inv), 32'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("t6_no_stale", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scs_flit_rx.md
Name: scs_flit_rx

Overview:
Receive end of the SCS-32 crosstalk-avoidance link. Accepts coded 32-bit flits off the wire (bit 31 = invert flag, bits 30:0 = payload, possibly inverted). Decodes them, buffers them in a small FIFO, and presents them downstream with a valid/ready handshake. Also keeps link statistics (flits, inverted flits, residual opposing-transition pairs) so the encoder's effectiveness can be measured in-system.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
CNT_W, 16, width of each statistics counter.

Ports:
clk  in  1  single clock, all state on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  coded flit present on in_data.
in_ready  out  1  receiver can accept a flit this cycle.
in_data  in  32  coded flit; [31] = inv flag, [30:0] = coded payload.
out_valid  out  1  decoded flit available.
out_ready  in  1  downstream accepts the flit.
out_data  out  31  decoded payload.
out_inv  out  1  inv flag the flit arrived with.
stat_clr  in  1  synchronous clear of the statistics counters.
flit_cnt  out  CNT_W  accepted flits, saturating.
inv_cnt  out  CNT_W  accepted flits with flag = 1, saturating.
t2_cnt  out  CNT_W  accumulated opposing-transition pairs on the wire, saturating.

Behaviour:
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- Decode before storage: payload = in_data[30:0] XOR {31{in_data[31]}}. Store {in_data[31], payload}.
- Wire bit 31 carries only the flag. There is no 32nd payload bit.
- FIFO:
  - rd_ptr/wr_ptr wrap modulo DEPTH; occupancy count 0..DEPTH.
  - in_ready = (count != DEPTH), decoded from registered count. No combinational path from out_ready.
  - out_valid = (count != 0).
  - out_data/out_inv = mem[rd_ptr], held stable while out_valid && !out_ready.
- Latency: flit accepted in cycle N appears on out_valid in cycle N+1 at the earliest. No bypass.
- Simultaneous accept and pop: count unchanged, both pointers advance.
  - When full, no accept is possible (in_ready = 0).
  - When empty, no pop is possible.
- Transition monitor:
  - prev_flit register holds the last accepted coded in_data (all 32 bits).
  - On accept, per-flit T2 count = number of i in 0..30 where {prev[i+1],prev[i]} -> {cur[i+1],cur[i]} is 10 -> 01 or 01 -> 10. Range 0..31.
  - Then prev_flit <= in_data.
  - prev_flit is not cleared by stat_clr.
- Counters:
  - On accept: flit_cnt += 1; inv_cnt += in_data[31]; t2_cnt += per-flit count.
  - All three saturate at 2^CNT_W-1 and never wrap.
  - stat_clr = 1 zeroes all three counters. Clear wins over a same-cycle increment.
- Reset (async, rst_n = 0), mid-operation included:
  - count, pointers, prev_flit and all counters go to 0.
  - in_ready = 1, out_valid = 0, out_data = 0, out_inv = 0.
  - FIFO contents are discarded.
- in_data is sampled only on accept. It is don't-care while in_valid = 0.

Decomposition:
- Shared package scs_pkg:
  - FLIT_W = 32, FLAG_BIT = 31, PAYLOAD_W = 31.
  - Typedef coded_flit_t (32 bits).
  - Typedef rx_entry_t {inv, payload[30:0]}.
  - Decode function used by both this block and the combinational decoder.
- One combinational sub-module, scs_t2_pair_count: inputs prev[31:0], cur[31:0]; output count[4:0] (opposing-pair popcount).
- FIFO and counters stay inline in scs_flit_rx.

Test Plan:
1. Reset release, in_data = 0x8000_0000 accepted, out_ready = 1:
   - Next cycle: out_valid = 1, out_data = 0x7FFF_FFFF, out_inv = 1.
   - Counters: flit_cnt = 1, inv_cnt = 1.
2. DEPTH = 4, out_ready = 0, in_valid held for 5 cycles with 0x0000_0001..0x0000_0005:
   - First 4 accepted, then in_ready = 0; flit_cnt = 4.
   - Raise out_ready: outputs 1, 2, 3, 4 in order, then out_valid = 0 and in_ready = 1.
3. After reset, accept 0x0000_0002 then 0x0000_0001:
   - t2_cnt = 1.
   - Then accept 0x5555_5555 after 0x2AAA_AAAA: 30 pairs oppose (i = 0..29); i = 30 does not, since bit 31 is 0 in both. t2_cnt = 31.
4. Full FIFO with out_ready = 1 and in_valid = 1 the same cycle:
   - Pop only; count goes 4 -> 3. in_ready = 1 the next cycle.
   - Then a simultaneous accept and pop holds count at 3.
5. CNT_W = 4, accept 20 flits with flag = 1: flit_cnt and inv_cnt hold at 15. Assert stat_clr during an accept: all counters = 0 the next cycle.
6. rst_n dropped asynchronously mid-cycle with 3 flits buffered:
   - Outputs immediately show out_valid = 0, in_ready = 1, counters = 0.
   - No stale flit appears after release.
